// File: rtl/beta_pkg.sv
// Shared widths, layer rules and channel state type for the beta-memory access scheduler.
// Used by b_burst_chan and b_ram_sched.
package beta_pkg;

  localparam int unsigned P    = 16;
  localparam int unsigned LW   = 5;
  localparam int unsigned AW   = 9;
  localparam int unsigned CW   = 6;
  localparam int unsigned MAXL = 8;

  typedef enum logic {StIdle, StBurst} chan_state_e;

  function automatic logic layer_ok(input logic [LW-1:0] layer);
    return (layer != '0) && (layer <= LW'(MAXL));
  endfunction

  // Illegal layers get a single pseudo-beat.
  function automatic logic [CW-1:0] beats_of(input logic [LW-1:0] layer);
    case (layer)
      LW'(8):  return CW'(8);
      LW'(7):  return CW'(4);
      LW'(6):  return CW'(2);
      default: return CW'(1);
    endcase
  endfunction

  // The top layer has a single node, so its address collapses to 0.
  function automatic logic [AW-1:0] eff_addr(input logic [LW-1:0] layer,
                                             input logic [AW-1:0] addr);
    return (layer == LW'(MAXL)) ? '0 : addr;
  endfunction

endpackage

// File: rtl/b_burst_chan.sv
// Single memory channel: latches a node command and expands it into a burst of beats.
// Instantiated once for the read port and once for the write port.
module b_burst_chan
  import beta_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic          i_stall,
  input  logic [LW-1:0] i_layer,
  input  logic [AW-1:0] i_addr,
  output logic          o_ready,
  output logic          o_accept,
  output logic          o_en,
  output logic [LW-1:0] o_layer,
  output logic [CW-1:0] o_cnt,
  output logic [AW-1:0] o_addr,
  output logic          o_busy,
  output logic          o_last
);

  chan_state_e   r_state;
  logic          r_en;
  logic [LW-1:0] r_layer;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_beats;
  logic          w_last;
  logic          w_accept;

  assign w_last   = (r_state == StBurst) && (r_cnt == r_beats - CW'(1));
  assign o_ready  = !rst && ((r_state == StIdle) || w_last) && !i_stall;
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_en    <= 1'b0;
      r_layer <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_beats <= '0;
    end else if (w_accept) begin
      // Covers back-to-back: a command taken on the last beat restarts at beat 0.
      r_state <= StBurst;
      r_en    <= layer_ok(i_layer);
      r_layer <= i_layer;
      r_addr  <= eff_addr(i_layer, i_addr);
      r_cnt   <= '0;
      r_beats <= beats_of(i_layer);
    end else if (w_last) begin
      r_state <= StIdle;
      r_en    <= 1'b0;
    end else if (r_state == StBurst) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_accept = w_accept;
  assign o_en     = r_en;
  assign o_layer  = r_layer;
  assign o_cnt    = r_cnt;
  assign o_addr   = r_addr;
  assign o_busy   = (r_state == StBurst);
  assign o_last   = w_last;

endmodule

// File: rtl/b_ram_sched.sv
// Beta-memory access scheduler: independent read/write burst channels, read-after-write
// hazard stall, registered read-return tags and error pulse. BSCHED_PERF_EN adds counters.
module b_ram_sched
  import beta_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [LW-1:0] wr_req_layer,
  input  logic [AW-1:0] wr_req_addr,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [LW-1:0] rd_req_layer,
  input  logic [AW-1:0] rd_req_addr,
  output logic          w_en,
  output logic [LW-1:0] layer_w,
  output logic [CW-1:0] cnta,
  output logic [AW-1:0] w_address,
  output logic          r_en,
  output logic [LW-1:0] layer_r,
  output logic [CW-1:0] cntb,
  output logic [AW-1:0] r_address,
  output logic          rd_data_valid,
  output logic          rd_data_last,
  output logic          cmd_err,
  output logic          busy
`ifdef BSCHED_PERF_EN
  ,
  output logic [15:0]   rd_stall_cnt,
  output logic [15:0]   wr_beat_cnt
`endif
);

  logic          w_wr_acc;
  logic          w_wr_busy;
  logic          w_wr_last;
  logic          w_rd_acc;
  logic          w_rd_busy;
  logic          w_rd_last;
  logic          w_hazard;
  logic [AW-1:0] w_rd_eff;
  logic          r_dvalid;
  logic          r_dlast;
  logic          r_cmd_err;

  b_burst_chan u_wr_chan (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (wr_req_valid),
    .i_stall  (1'b0),
    .i_layer  (wr_req_layer),
    .i_addr   (wr_req_addr),
    .o_ready  (wr_req_ready),
    .o_accept (w_wr_acc),
    .o_en     (w_en),
    .o_layer  (layer_w),
    .o_cnt    (cnta),
    .o_addr   (w_address),
    .o_busy   (w_wr_busy),
    .o_last   (w_wr_last)
  );

  // A write's final beat lands before any read issued off it, so only earlier beats stall.
  assign w_rd_eff = eff_addr(rd_req_layer, rd_req_addr);
  assign w_hazard = (w_wr_busy && !w_wr_last && (layer_w == rd_req_layer) &&
                     (w_address == w_rd_eff)) ||
                    (w_wr_acc && (wr_req_layer == rd_req_layer) &&
                     (eff_addr(wr_req_layer, wr_req_addr) == w_rd_eff));

  b_burst_chan u_rd_chan (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (rd_req_valid),
    .i_stall  (w_hazard),
    .i_layer  (rd_req_layer),
    .i_addr   (rd_req_addr),
    .o_ready  (rd_req_ready),
    .o_accept (w_rd_acc),
    .o_en     (r_en),
    .o_layer  (layer_r),
    .o_cnt    (cntb),
    .o_addr   (r_address),
    .o_busy   (w_rd_busy),
    .o_last   (w_rd_last)
  );

  // Pseudo-beats of illegal reads still return one (zero) data beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvalid  <= 1'b0;
      r_dlast   <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_dvalid  <= w_rd_busy;
      r_dlast   <= w_rd_last;
      r_cmd_err <= (w_wr_acc && !layer_ok(wr_req_layer)) ||
                   (w_rd_acc && !layer_ok(rd_req_layer));
    end
  end

  assign rd_data_valid = r_dvalid;
  assign rd_data_last  = r_dlast;
  assign cmd_err       = r_cmd_err;
  assign busy          = w_wr_busy || w_rd_busy;

`ifdef BSCHED_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (rd_req_valid && w_hazard && (r_stall_cnt != 16'hffff)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_en && (r_beat_cnt != 16'hffff)) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  assign rd_stall_cnt = r_stall_cnt;
  assign wr_beat_cnt  = r_beat_cnt;
`endif

endmodule

// File: doc/b_ram_sched.md
Name: b_ram_sched

Overview:
- Access scheduler for the per-layer partial-sum (beta) memory of the 1024-bit, 16-lane SCAN decoder.
- Accepts node-level read and write commands from the decoder core, each carrying a layer and a node address.
- Expands each command into the per-beat memory controls: layer, beat count, node address and enable, on independent read and write ports.
- Enforces read-after-write ordering on the same node and tags returned read data with valid/last.

Parameters:
- P, 16, lanes per beat (beta values per read beat; write beat carries 2*P).
- LW, 5, layer field width.
- AW, 9, node address width.
- CW, 6, beat-count width.
- MAXL, 8, highest legal layer.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_req_valid  in  1  write command valid
- wr_req_ready  out  1  write command accepted when valid&&ready
- wr_req_layer  in  LW  write layer
- wr_req_addr  in  AW  write node address
- rd_req_valid  in  1  read command valid
- rd_req_ready  out  1  read command accepted when valid&&ready
- rd_req_layer  in  LW  read layer
- rd_req_addr  in  AW  read node address
- w_en  out  1  memory write enable; also the beat strobe telling the producer to advance b_in
- layer_w  out  LW  memory write layer
- cnta  out  CW  write beat index
- w_address  out  AW  write node address
- r_en  out  1  memory read enable
- layer_r  out  LW  memory read layer
- cntb  out  CW  read beat index
- r_address  out  AW  read node address
- rd_data_valid  out  1  memory read data valid this cycle
- rd_data_last  out  1  last beat of the read command
- cmd_err  out  1  one-cycle pulse on acceptance of an illegal layer
- busy  out  1  either channel in BURST

Behaviour:
- Reset: all outputs 0, both channels IDLE. Readies are 0 during reset and rise the first cycle after reset deasserts. Reset mid-burst aborts the burst with no further enables.
- Beats per command, both channels: beats(L) = 8 for L=8, 4 for L=7, 2 for L=6, 1 for 1≤L≤5.
- Channel FSM (read and write identical and independent):
  - IDLE -> BURST on accept. Layer, address and beats are latched; first enable is asserted the cycle after accept.
  - In BURST: enable=1 every cycle; the count output runs 0..beats-1, one step per cycle, no bubbles.
  - On the last beat: -> IDLE, unless a new command is accepted that same cycle, in which case the next burst starts on the following cycle (back-to-back, zero gap).
- Ready rule: ready = (IDLE or last beat) and no hazard stall.
- Address/layer outputs:
  - Hold the latched command values for the whole burst, and hold the last values while IDLE with enable=0.
  - L=8 forces the node address output to 0.
  - L=7 and L=6 drive the node address unchanged; the memory applies the shift.
- Illegal layer (0 or >MAXL):
  - Command is accepted with a single-cycle pseudo-beat: enable stays 0.
  - cmd_err pulses the cycle after accept.
  - On the read channel, rd_data_valid and rd_data_last still pulse once, with data reading as zero.
- Read-after-write hazard:
  - A read is stalled (rd_req_ready=0) while the write channel is in BURST with an equal latched layer and address.
  - A read is also stalled when a write command with equal layer and address is being accepted that same cycle (write-first).
  - Reads to other layers or addresses proceed concurrently with writes.
- Read return: the memory output is registered, so rd_data_valid = r_en delayed 1 cycle and rd_data_last = (r_en on last beat) delayed 1 cycle.
- Write data: none passes through this block. The producer presents beat k of b_in in the cycle w_en=1 with cnta=k.

Optional Feature:
- Macro: BSCHED_PERF_EN.
- Defined:
  - Adds a 16-bit saturating output rd_stall_cnt, counting cycles with rd_req_valid=1 and rd_req_ready=0 due to the hazard.
  - Adds a 16-bit saturating output wr_beat_cnt, counting w_en cycles.
  - Both clear on rst.
- Undefined: neither port exists; no logic is generated.

Decomposition:
- Shared package beta_pkg holds: MAXL, P, the LW/AW/CW widths, a beats_of(layer) function, and a layer-legality function.
- One sub-module, b_burst_chan: a single-channel FSM with latched layer/address and beat counter, instantiated twice (read and write).
- The top level adds hazard compare, read-return pipeline, error pulse and perf counters.

Test Plan:
- Write cmd L=8 addr=5 -> w_en high 8 cycles, cnta 0..7, w_address=0, wr_req_ready high on the 8th beat only.
- Read cmd L=7 addr=1 -> r_en 4 cycles, cntb 0..3, r_address=1; rd_data_valid 4 cycles lagging by 1, rd_data_last on the 4th.
- Write L=6 addr=2 in BURST while read L=6 addr=2 is valid -> rd_req_ready=0 until the write's last beat; first r_en the cycle after the final w_en. The same read to addr=3 proceeds concurrently.
- Back-to-back reads L=5 addr=0,1,2 held valid -> r_en continuous 3 cycles, r_address 0,1,2, three rd_data_last pulses.
- Read cmd L=0, then write cmd L=9 -> each accepted, enables stay 0, cmd_err pulses once per command; the read returns one valid/last pulse.
- rst asserted on the 3rd beat of an L=8 write -> w_en 0 the next cycle, all outputs 0, wr_req_ready=1 the cycle after rst falls.
